axi_lite_reg_bank: RTL

//  Parametrised AXI4-Lite slave register bank for game-peripheral IP.

---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_reg_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and byte-enable merge helper for the AXI4-Lite register bank.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // Widest supported bus; narrower callers zero-extend in and truncate out.
  function automatic logic [MAX_DATA_W-1:0] apply_wstrb(
    input logic [MAX_DATA_W-1:0] old,
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: byte-enabled RW registers, hardware-status RO
// registers, SLVERR decode, and per-register write/read strobes to user logic.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic                  r_active;
  logic                  r_aw_held, r_w_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  resp_t                 r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REGS-1:0]   r_wr_pulse, r_rd_pulse;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_cm_ok, w_rd_ok;
  logic [IDX_W-1:0]      w_cm_idx, w_ar_idx;
  logic [DATA_WIDTH-1:0] w_cm_data, w_rd_data;
  logic [STRB_W-1:0]     w_cm_strb;
  logic [NUM_REGS-1:0]   w_cm_hit, w_rd_hit;
  logic                  w_unused_ok;

  // r_active keeps every READY low while reset is held and for the release cycle.
  assign AWREADY = r_active && (r_wstate == W_IDLE) && !r_aw_held;
  assign WREADY  = r_active && (r_wstate == W_IDLE) && !r_w_held;
  assign ARREADY = r_active && (r_rstate == R_IDLE);
  assign BVALID  = (r_wstate == W_RESP);
  assign RVALID  = (r_rstate == R_DATA);
  assign BRESP   = r_bresp;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;

  assign wr_pulse = r_wr_pulse;
  assign rd_pulse = r_rd_pulse;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_w_hs   = WVALID && WREADY;
  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_commit = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // A channel arriving on the commit edge bypasses its holding register.
  assign w_cm_idx  = r_aw_held ? r_aw_idx : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_cm_data = r_w_held ? r_wdata : WDATA;
  assign w_cm_strb = r_w_held ? r_wstrb : WSTRB;
  assign w_ar_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  assign w_unused_ok = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0], regs_in};

  always_comb begin
    w_cm_hit  = '0;
    w_rd_hit  = '0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_cm_idx) == i) w_cm_hit[i] = !RO_MASK[i];
      if (int'(w_ar_idx) == i) begin
        w_rd_hit[i] = 1'b1;
        w_rd_data   = RO_MASK[i] ? regs_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  assign w_cm_ok = |w_cm_hit;
  assign w_rd_ok = |w_rd_hit;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_active   <= 1'b0;
      r_wstate   <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      r_active   <= 1'b1;
      r_wstate   <= w_wstate_nxt;
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_held  <= 1'b0;
        r_w_held   <= 1'b0;
        r_bresp    <= w_cm_ok ? OKAY : SLVERR;
        r_wr_pulse <= w_cm_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_cm_hit[i]) begin
            r_regs[i] <= DATA_WIDTH'(apply_wstrb(MAX_DATA_W'(r_regs[i]), MAX_DATA_W'(w_cm_data),
                                                 MAX_STRB_W'(w_cm_strb)));
          end
        end
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_aw_idx <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    if (w_w_hs) begin
      r_wdata <= WDATA;
      r_wstrb <= WSTRB;
    end
  end

  // Read data is captured from the pre-edge register array, so a same-edge write is not visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate   <= R_IDLE;
      r_rdata    <= '0;
      r_rresp    <= OKAY;
      r_rd_pulse <= '0;
    end else begin
      r_rstate   <= w_rstate_nxt;
      r_rd_pulse <= w_ar_hs ? w_rd_hit : '0;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_ok ? OKAY : SLVERR;
      end
    end
  end

endmodule
